// File: rtl/wb_vmemem_bridge_pkg.sv
// Shared types and constants for the Wishbone to register-block memory bridge.
package wb_vmemem_bridge_pkg;

  localparam int ADDR_W                 = 18;
  localparam int DATA_W                 = 32;
  localparam int TIMEOUT_CYCLES_DEFAULT = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/wb_vmemem_timeout.sv
// Clear/enable counter that saturates at LIMIT and flags expiry once LIMIT is reached.
module wb_vmemem_timeout #(
  parameter int LIMIT = 255
) (
  input  logic Clk,
  input  logic Rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_C = CW'(LIMIT);

  logic [CW-1:0] count_reg;

  // Stops at LIMIT so a long stall can never wrap back to a small count.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && (count_reg != LIMIT_C)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign expired = (count_reg == LIMIT_C);

endmodule

// File: rtl/wb_vmemem_bridge.sv
// Wishbone slave driving a register block's strobe/done memory port, one transaction at a time.
// Optional timeout counter enabled by defining WB_VMEMEM_BRIDGE_TIMEOUT_EN.
module wb_vmemem_bridge
  import wb_vmemem_bridge_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [ADDR_W-1:0] wb_adr_i,
  input  logic [DATA_W-1:0] wb_dat_i,
  output logic [DATA_W-1:0] wb_dat_o,
  output logic              wb_ack_o,
  output logic              wb_err_o,
  output logic              wb_stall_o,
  output logic [ADDR_W-1:0] VMEAddr,
  output logic [DATA_W-1:0] VMEWrData,
  output logic              VMERdMem,
  output logic              VMEWrMem,
  input  logic [DATA_W-1:0] VMERdData,
  input  logic              VMERdDone,
  input  logic              VMEWrDone,
  input  logic              VMERdError,
  input  logic              VMEWrError
);

  state_t state_reg;
  logic   we_reg;
  logic   aborted_reg;
  logic   sel_done;
  logic   sel_err;
  logic   timeout_expired;

  // Only the completion inputs of the operation in flight are considered.
  assign sel_done   = we_reg ? VMEWrDone  : VMERdDone;
  assign sel_err    = we_reg ? VMEWrError : VMERdError;
  assign wb_stall_o = (state_reg != IDLE);

`ifdef WB_VMEMEM_BRIDGE_TIMEOUT_EN
  wb_vmemem_timeout #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .Clk    (Clk),
    .Rst    (Rst),
    .clear  (state_reg == IDLE),
    .enable (state_reg == WAIT),
    .expired(timeout_expired)
  );
`else
  assign timeout_expired = 1'b0;
`endif

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_reg   <= IDLE;
      we_reg      <= 1'b0;
      aborted_reg <= 1'b0;
      VMEAddr     <= '0;
      VMEWrData   <= '0;
      VMERdMem    <= 1'b0;
      VMEWrMem    <= 1'b0;
      wb_ack_o    <= 1'b0;
      wb_err_o    <= 1'b0;
      wb_dat_o    <= '0;
    end else begin
      VMERdMem <= 1'b0;
      VMEWrMem <= 1'b0;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (wb_cyc_i && wb_stb_i) begin
            VMEAddr     <= wb_adr_i;
            VMEWrData   <= wb_dat_i;
            we_reg      <= wb_we_i;
            VMEWrMem    <= wb_we_i;
            VMERdMem    <= !wb_we_i;
            aborted_reg <= 1'b0;
            state_reg   <= WAIT;
          end
        end
        WAIT: begin
          // A master that drops the cycle still lets the downstream op finish, silently.
          if (!wb_cyc_i) aborted_reg <= 1'b1;
          if (sel_done || sel_err || timeout_expired) begin
            state_reg <= RESP;
            if (sel_done && !sel_err && !we_reg) wb_dat_o <= VMERdData;
            if (wb_cyc_i && !aborted_reg) begin
              if (sel_done && !sel_err) wb_ack_o <= 1'b1;
              else                      wb_err_o <= 1'b1;
            end
          end
        end
        RESP: begin
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_vmemem_bridge.sv
// Self-checking bench: register-block model downstream, randomized Wishbone traffic upstream.
module tb_wb_vmemem_bridge;

  localparam int TO = 8;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic        wb_we_i = 1'b0;
  logic [17:0] wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o, wb_err_o, wb_stall_o;
  logic [17:0] VMEAddr;
  logic [31:0] VMEWrData;
  logic        VMERdMem, VMEWrMem;
  logic [31:0] VMERdData = '0;
  logic        VMERdDone = 1'b0, VMEWrDone = 1'b0, VMERdError = 1'b0, VMEWrError = 1'b0;

  int model_mode = 0;  // 0 normal, 1 silent, 2 answer with error
  logic [31:0] model_mem [16];
  logic [31:0] ref_mem [16];
  logic [31:0] exp_dat;

  int errors = 0;
  int checks = 0;

  // results of the most recent run_txn
  int t_strobe_cyc, t_resp_cyc, t_idle_cyc, t_ack, t_err, t_strobes, t_both;
  logic        t_strobe_we;
  logic [17:0] t_strobe_addr;
  logic [31:0] t_strobe_data;

  always #5 Clk = ~Clk;

  wb_vmemem_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .Clk(Clk), .Rst(Rst),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_stall_o(wb_stall_o),
    .VMEAddr(VMEAddr), .VMEWrData(VMEWrData),
    .VMERdMem(VMERdMem), .VMEWrMem(VMEWrMem),
    .VMERdData(VMERdData), .VMERdDone(VMERdDone), .VMEWrDone(VMEWrDone),
    .VMERdError(VMERdError), .VMEWrError(VMEWrError)
  );

  // Register-block model: answers one cycle after the strobe.
  always @(posedge Clk) begin
    VMERdDone  <= 1'b0;
    VMEWrDone  <= 1'b0;
    VMERdError <= 1'b0;
    VMEWrError <= 1'b0;
    if (Rst) begin
      for (int i = 0; i < 16; i++) model_mem[i] <= 32'h000000A5 + 32'(i) * 32'h101;
    end else begin
      if (VMERdMem && model_mode != 1) begin
        VMERdDone  <= 1'b1;
        VMERdError <= (model_mode == 2);
        VMERdData  <= model_mem[VMEAddr[3:0]];
      end
      if (VMEWrMem && model_mode != 1) begin
        VMEWrDone  <= 1'b1;
        VMEWrError <= (model_mode == 2);
        if (model_mode == 0) model_mem[VMEAddr[3:0]] <= VMEWrData;
      end
    end
  end

  task automatic init_ref();
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'h000000A5 + 32'(i) * 32'h101;
    exp_dat = 32'h0;
  endtask

  // One request; cycle c=1 is the cycle right after the accepting edge.
  task automatic run_txn(input logic we, input logic [17:0] adr, input logic [31:0] dat,
                         input int max_cycles);
    int guard;
    t_strobe_cyc = 0; t_resp_cyc = 0; t_idle_cyc = 0;
    t_ack = 0; t_err = 0; t_strobes = 0; t_both = 0;
    t_strobe_we = 1'b0; t_strobe_addr = '0; t_strobe_data = '0;
    @(negedge Clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr; wb_dat_i = dat;
    guard = 0;
    while (wb_stall_o && guard < 50) begin
      @(negedge Clk);
      guard++;
    end
    if (wb_stall_o) begin
      checks++; errors++;
      $display("FAIL accept_wait: stall still %0b after %0d cycles, required 0", wb_stall_o, guard);
    end
    @(posedge Clk);
    #1;
    wb_stb_i = 1'b0;
    for (int c = 1; c <= max_cycles; c++) begin
      if (VMERdMem || VMEWrMem) begin
        if (t_strobes == 0) begin
          t_strobe_cyc = c; t_strobe_we = VMEWrMem;
          t_strobe_addr = VMEAddr; t_strobe_data = VMEWrData;
        end
        t_strobes++;
      end
      if (wb_ack_o) begin t_ack++; t_resp_cyc = c; end
      if (wb_err_o) begin t_err++; t_resp_cyc = c; end
      if (wb_ack_o && wb_err_o) t_both++;
      if (!wb_stall_o) begin t_idle_cyc = c; break; end
      @(posedge Clk);
      #1;
    end
    wb_cyc_i = 1'b0;
    $display("txn we=%0b adr=%0d wdat=%h ack=%0d err=%0d resp_cyc=%0d rdat=%h",
             we, adr, dat, t_ack, t_err, t_resp_cyc, wb_dat_o);
  endtask

  task automatic test_reset();
    Rst = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    checks++; if (wb_ack_o !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b required 0", wb_ack_o); end
    checks++; if (wb_err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b required 0", wb_err_o); end
    checks++; if (wb_stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b required 0", wb_stall_o); end
    checks++; if (wb_dat_o !== 32'h0) begin errors++; $display("FAIL reset_dat: got %h required 0", wb_dat_o); end
    checks++; if ({VMERdMem, VMEWrMem} !== 2'b00) begin errors++; $display("FAIL reset_strobes: got %b required 00", {VMERdMem, VMEWrMem}); end
    checks++; if (VMEAddr !== 18'h0 || VMEWrData !== 32'h0) begin errors++; $display("FAIL reset_vme: got addr %h data %h required 0", VMEAddr, VMEWrData); end
    @(negedge Clk);
    Rst = 1'b0;
    init_ref();
  endtask

  task automatic test_read();
    run_txn(1'b0, 18'd0, 32'h0, 20);
    exp_dat = ref_mem[0];
    checks++; if (t_strobe_cyc !== 1 || t_strobe_we !== 1'b0 || t_strobes !== 1) begin errors++; $display("FAIL read_strobe: cyc %0d we %0b n %0d required cyc 1 read n 1", t_strobe_cyc, t_strobe_we, t_strobes); end
    checks++; if (t_ack !== 1 || t_err !== 0 || t_resp_cyc !== 3) begin errors++; $display("FAIL read_ack: ack %0d err %0d cyc %0d required 1 0 3", t_ack, t_err, t_resp_cyc); end
    checks++; if (wb_dat_o !== 32'h000000A5) begin errors++; $display("FAIL read_data: got %h required 000000a5", wb_dat_o); end
    checks++; if (t_idle_cyc !== 4) begin errors++; $display("FAIL read_idle: got cyc %0d required 4", t_idle_cyc); end
  endtask

  task automatic test_write();
    run_txn(1'b1, 18'd1, 32'h1234, 20);
    ref_mem[1] = 32'h1234;
    checks++; if (t_strobes !== 1 || t_strobe_we !== 1'b1 || t_strobe_addr !== 18'd1 || t_strobe_data !== 32'h1234) begin errors++; $display("FAIL write_strobe: n %0d we %0b addr %h data %h required 1 1 1 1234", t_strobes, t_strobe_we, t_strobe_addr, t_strobe_data); end
    checks++; if (t_ack !== 1 || t_err !== 0) begin errors++; $display("FAIL write_ack: ack %0d err %0d required 1 0", t_ack, t_err); end
    checks++; if (wb_dat_o !== exp_dat) begin errors++; $display("FAIL write_dat_hold: got %h required %h", wb_dat_o, exp_dat); end
    run_txn(1'b0, 18'd1, 32'h0, 20);
    exp_dat = ref_mem[1];
    checks++; if (t_ack !== 1 || wb_dat_o !== 32'h00001234) begin errors++; $display("FAIL write_readback: ack %0d data %h required 1 00001234", t_ack, wb_dat_o); end
  endtask

  task automatic test_random();
    logic        we;
    logic [17:0] adr;
    logic [31:0] dat;
    for (int i = 0; i < 24; i++) begin
      we  = 1'($urandom_range(0, 1));
      adr = 18'($urandom_range(0, 15));
      dat = $urandom;
      run_txn(we, adr, dat, 20);
      if (we) ref_mem[adr[3:0]] = dat;
      else    exp_dat = ref_mem[adr[3:0]];
      checks++; if (t_ack !== 1 || t_err !== 0 || t_resp_cyc !== 3 || t_both !== 0) begin errors++; $display("FAIL rand_resp[%0d]: ack %0d err %0d cyc %0d both %0d required 1 0 3 0", i, t_ack, t_err, t_resp_cyc, t_both); end
      checks++; if (wb_dat_o !== exp_dat) begin errors++; $display("FAIL rand_data[%0d]: got %h required %h", i, wb_dat_o, exp_dat); end
      checks++; if (t_strobe_addr !== adr) begin errors++; $display("FAIL rand_addr[%0d]: got %h required %h", i, t_strobe_addr, adr); end
    end
  endtask

  task automatic test_rd_error();
    model_mode = 2;
    run_txn(1'b0, 18'd4, 32'h0, 20);
    model_mode = 0;
    checks++; if (t_err !== 1 || t_ack !== 0 || t_resp_cyc !== 3) begin errors++; $display("FAIL rderr_resp: err %0d ack %0d cyc %0d required 1 0 3", t_err, t_ack, t_resp_cyc); end
    checks++; if (wb_dat_o !== exp_dat) begin errors++; $display("FAIL rderr_dat_hold: got %h required %h", wb_dat_o, exp_dat); end
  endtask

`ifdef WB_VMEMEM_BRIDGE_TIMEOUT_EN
  task automatic test_timeout();
    model_mode = 1;
    run_txn(1'b0, 18'd2, 32'h0, TO + 10);
    model_mode = 0;
    checks++; if (t_err !== 1 || t_ack !== 0 || t_resp_cyc !== TO + 2) begin errors++; $display("FAIL timeout_err: err %0d ack %0d cyc %0d required 1 0 %0d", t_err, t_ack, t_resp_cyc, TO + 2); end
    checks++; if (t_idle_cyc !== TO + 3) begin errors++; $display("FAIL timeout_idle: got cyc %0d required %0d", t_idle_cyc, TO + 3); end
  endtask
`endif

  task automatic test_back_to_back();
    int   accepts = 0, nstb = 0, nack = 0;
    int   sc0 = -1, sc1 = -1;
    logic acc_now;
    @(negedge Clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 18'd2;
    for (int c = 0; c < 16; c++) begin
      acc_now = !wb_stall_o && wb_stb_i;
      @(posedge Clk);
      #1;
      if (acc_now) begin
        accepts++;
        if (accepts == 2) wb_stb_i = 1'b0;
      end
      if (VMERdMem) begin
        if (nstb == 0) sc0 = c;
        else if (nstb == 1) sc1 = c;
        nstb++;
      end
      if (wb_ack_o) nack++;
      @(negedge Clk);
    end
    wb_cyc_i = 1'b0;
    exp_dat = ref_mem[2];
    $display("txn back_to_back accepts=%0d strobes=%0d acks=%0d gap=%0d", accepts, nstb, nack, sc1 - sc0);
    checks++; if (accepts !== 2 || nstb !== 2) begin errors++; $display("FAIL b2b_count: accepts %0d strobes %0d required 2 2", accepts, nstb); end
    checks++; if (sc1 - sc0 !== 4) begin errors++; $display("FAIL b2b_gap: got %0d required 4", sc1 - sc0); end
    checks++; if (nack !== 2 || wb_dat_o !== exp_dat) begin errors++; $display("FAIL b2b_ack: acks %0d data %h required 2 %h", nack, wb_dat_o, exp_dat); end
  endtask

  task automatic test_abort_rst();
    int resp = 0;
    @(negedge Clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 18'd3;
    @(posedge Clk);
    #1;
    wb_stb_i = 1'b0;
    Rst = 1'b1;
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    init_ref();
    checks++; if ({wb_ack_o, wb_err_o, wb_stall_o, VMERdMem, VMEWrMem} !== 5'b0 || VMEAddr !== 18'h0 || wb_dat_o !== 32'h0) begin errors++; $display("FAIL rst_abort_outputs: ack %b err %b stall %b rd %b wr %b addr %h dat %h required all 0", wb_ack_o, wb_err_o, wb_stall_o, VMERdMem, VMEWrMem, VMEAddr, wb_dat_o); end
    for (int c = 0; c < 6; c++) begin
      if (wb_ack_o || wb_err_o) resp++;
      @(posedge Clk);
      #1;
    end
    wb_cyc_i = 1'b0;
    checks++; if (resp !== 0) begin errors++; $display("FAIL rst_abort_noresp: got %0d responses required 0", resp); end
    run_txn(1'b0, 18'd3, 32'h0, 20);
    exp_dat = ref_mem[3];
    checks++; if (t_ack !== 1 || wb_dat_o !== exp_dat) begin errors++; $display("FAIL rst_abort_next: ack %0d data %h required 1 %h", t_ack, wb_dat_o, exp_dat); end
  endtask

  task automatic test_cyc_drop();
    int resp = 0, strobes = 0;
    @(negedge Clk);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 18'd5; wb_dat_i = 32'hCAFE0005;
    @(posedge Clk);
    #1;
    wb_stb_i = 1'b0;
    wb_cyc_i = 1'b0;
    ref_mem[5] = 32'hCAFE0005;
    for (int c = 1; c <= 6; c++) begin
      if (wb_ack_o || wb_err_o) resp++;
      if (VMEWrMem) strobes++;
      @(posedge Clk);
      #1;
    end
    checks++; if (resp !== 0 || strobes !== 1) begin errors++; $display("FAIL cyc_drop_noresp: responses %0d strobes %0d required 0 1", resp, strobes); end
    checks++; if (wb_stall_o !== 1'b0) begin errors++; $display("FAIL cyc_drop_idle: stall %b required 0", wb_stall_o); end
    run_txn(1'b0, 18'd5, 32'h0, 20);
    exp_dat = ref_mem[5];
    checks++; if (t_ack !== 1 || wb_dat_o !== exp_dat) begin errors++; $display("FAIL cyc_drop_next: ack %0d data %h required 1 %h", t_ack, wb_dat_o, exp_dat); end
  endtask

  initial begin
    init_ref();
    test_reset();
    test_read();
    test_write();
    test_random();
    test_rd_error();
`ifdef WB_VMEMEM_BRIDGE_TIMEOUT_EN
    test_timeout();
`endif
    test_back_to_back();
    test_abort_rst();
    test_cyc_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

endmodule
